// File: rtl/mem_port_arbiter.sv
// Arbitrates one start/done memory port between fetch (i_*) and data (d_*) requesters.
// Optional feature: define ARB_ROUND_ROBIN_EN for last-owner based priority under contention.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_rd,
    output logic          m_wr,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_done,
    output logic          busy,
    output logic          err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RESP = 2'd2} state_t;

    // Handshake: requests are levels held until the matching one-cycle done
    // pulse; m_rd/m_wr are levels held until m_done, which is honoured only in ACC.
    state_t        state_q, state_d;
    logic          owner_d_q;     // 1 = data side owns the current transaction
    logic          err_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_d, grant_i, done_ok, abort;
    logic          d_req, pri_d;
    logic [CW-1:0] cnt_inc;

    assign d_req   = d_rd | d_wr;
    assign cnt_inc = cnt_q + 1'b1;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;               // 1 = data side was served last
    assign pri_d = ~last_d_q;
`else
    assign pri_d = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = 1'b0;
        grant_i = 1'b0;
        done_ok = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_req || pri_d)) begin
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end
                if (grant_d || grant_i) begin
                    state_d = ACC;
                    cnt_d   = '0;
                end
            end
            ACC: begin
                // A completion in the last allowed cycle beats the watchdog.
                if (m_done) begin
                    done_ok = 1'b1;
                    state_d = RESP;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    abort   = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_d_q <= 1'b0;
            err_q     <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_rd      <= 1'b0;
            m_wr      <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant_d) begin
                owner_d_q <= 1'b1;
                err_q     <= 1'b0;
                m_addr    <= d_addr;
                if (d_wr) begin
                    m_wdata <= d_wdata;
                    m_wr    <= 1'b1;
                end else begin
                    m_rd <= 1'b1;
                end
            end
            if (grant_i) begin
                owner_d_q <= 1'b0;
                err_q     <= 1'b0;
                m_addr    <= i_addr;
                m_rd      <= 1'b1;
            end
            if (done_ok) begin
                m_rd <= 1'b0;
                m_wr <= 1'b0;
                if (m_rd) begin
                    if (owner_d_q) d_rdata <= m_rdata;
                    else           i_rdata <= m_rdata;
                end
            end
            if (abort) begin
                m_rd  <= 1'b0;
                m_wr  <= 1'b0;
                err_q <= 1'b1;
                if (owner_d_q) d_rdata <= '0;
                else           i_rdata <= '0;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if (grant_d) begin
            last_d_q <= 1'b1;
        end else if (grant_i) begin
            last_d_q <= 1'b0;
        end
    end
`endif

    assign i_done    = (state_q == RESP) && !owner_d_q;
    assign d_done    = (state_q == RESP) && owner_d_q;
    assign err       = (state_q == RESP) && err_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port (start/done handshake) between the instruction-fetch requester and the data (load/store) requester of the pipelined RV32 core.
- Sequences one transaction at a time: grants the port, drives the memory strobes, and waits for `m_done`.
- Returns read data plus a one-cycle done pulse to the granted requester; the pipeline's stall logic consumes that pulse.
- A timeout watchdog stops a missing `m_done` from hanging the core.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum cycles waiting for `m_done` before abort (1..2^CW-1)
- CW, 8, timeout counter width

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; level, held until i_done
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetched word, valid with i_done
- i_done  out  1  one-cycle completion pulse to fetch
- d_rd  in  1  data read request; level, held until d_done
- d_wr  in  1  data write request; level, held until d_done
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid with d_done
- d_done  out  1  one-cycle completion pulse to data side
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rd  out  1  memory read strobe; level for the whole transaction
- m_wr  out  1  memory write strobe; level for the whole transaction
- m_rdata  in  DW  memory read data, sampled when m_done=1
- m_done  in  1  memory completion pulse
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse coincident with the done pulse of an aborted transaction

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE.
  - All outputs 0; i_rdata, d_rdata, m_addr, m_wdata = 0.
  - Timeout counter = 0.
  - No done pulse is produced for the aborted transaction.
- State IDLE:
  - Requests are evaluated every cycle.
  - Data has priority: any of d_rd/d_wr set wins over i_req.
  - d_rd and d_wr both set is treated as a write.
  - On grant, at the clock edge:
    - register m_addr, plus m_wdata for writes;
    - assert m_rd or m_wr;
    - clear the counter;
    - go to ACC, recording the owner (I or D).
  - Fetch is always a read.
- State ACC:
  - Strobe and address are held stable.
  - Counter increments each cycle without m_done.
  - When m_done=1:
    - capture m_rdata into the owner's rdata register (reads only; on writes the rdata register keeps its old value);
    - drop the strobe at the same edge;
    - go to RESP.
  - When the counter reaches TIMEOUT with m_done=0:
    - drop the strobe;
    - set owner rdata=0;
    - go to RESP with the err flag set.
  - m_done and the timeout in the same cycle: m_done wins, no err.
- State RESP:
  - Owner's done pulses high for exactly this cycle; err pulses too if flagged.
  - Next state is IDLE unconditionally. This turnaround cycle guarantees requesters see done before their requests are re-evaluated.
- Latency:
  - Request seen in IDLE at cycle 0 → strobe high from cycle 1.
  - m_done at cycle k → done at cycle k+1, IDLE at k+2.
  - Next strobe no earlier than k+3.
- m_done outside ACC is ignored.
- A requester that drops its request mid-transaction does not cancel it: the transaction completes and done still pulses.
- Changes to i_addr/d_addr/d_wdata after grant have no effect (registered).
- i_done and d_done are never high in the same cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A one-bit last-owner register (reset to I) selects priority.
  - When both sides request in IDLE, the side not served last is granted.
  - A single requester is granted immediately regardless.
- Undefined: fixed data-over-fetch priority as described under Behaviour, with no last-owner register.

Test Plan:
- Fetch read:
  - Stimulus: i_req=1, i_addr=0x100; memory returns m_done with m_rdata=0xDEADBEEF 3 cycles after m_rd rises.
  - Required: m_rd high for 3 cycles, m_addr=0x100, i_done one cycle after m_done, i_rdata=0xDEADBEEF, err=0.
- Store:
  - Stimulus: d_wr=1, d_addr=0x2000, d_wdata=0x12345678; m_done after 1 cycle.
  - Required: m_wr=1, m_rd=0, m_wdata=0x12345678, single d_done pulse, d_rdata unchanged.
- Contention:
  - Stimulus: i_req and d_rd asserted together in IDLE.
  - Required without macro: data granted first, fetch granted afterwards (i_done ≥3 cycles after d_done).
  - Required with ARB_ROUND_ROBIN_EN and last owner=D: fetch granted first.
- Timeout:
  - Stimulus: TIMEOUT=4, d_rd=1, m_done never asserted.
  - Required: m_rd drops after 4 cycles, d_done and err pulse together, d_rdata=0, busy returns low.
- Reset mid-transaction:
  - Stimulus: RST_N low while m_rd=1, then m_done pulses during reset.
  - Required: m_rd, busy and the done pulses go 0 immediately, no done afterwards, arbiter grants a new i_req normally after reset release.
- Spurious/dropped:
  - Stimulus: m_done pulsed in IDLE; i_req dropped 1 cycle after grant.
  - Required: the spurious m_done is ignored; the fetch transaction still completes with one i_done.
